// File: rtl/onewire_slave.sv
// 1-Wire responder: bus-reset detect, presence pulse, write-slot byte
// decode and read-slot byte transmit on a shared open-drain line.
//
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   owr_i               raw line level (pin = owr_e ? 0 : z)
//   owr_e               pull the line low when 1
//   bus_rst             1-cycle pulse on bus reset detection
//   rx_data, rx_vld     received byte (LSB first) and its 1-cycle strobe
//   tx_data, tx_vld     byte to send in the next 8 read slots, request
//   tx_rdy              request accepted when tx_vld & tx_rdy
//   tx_done             1-cycle pulse after the 8th transmitted slot
module onewire_slave #(
    parameter int CW    = 14,
    parameter int T_RST = 13107,
    parameter int T_PDH = 983,
    parameter int T_PDL = 3932,
    parameter int T_SMP = 983,
    parameter int T_RD0 = 1311
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       owr_i,
    output logic       owr_e,
    output logic       bus_rst,
    output logic [7:0] rx_data,
    output logic       rx_vld,
    input  logic [7:0] tx_data,
    input  logic       tx_vld,
    output logic       tx_rdy,
    output logic       tx_done
);

    // A low pulse shorter than C_GLT is line noise, not a slot. A longer
    // pulse that ends before the sample point is a short (1) slot and is
    // sampled on its rising edge.
    localparam logic [CW-1:0] C_RST  = CW'(T_RST);
    localparam logic [CW-1:0] C_PDH  = CW'(T_PDH);
    localparam logic [CW-1:0] C_PDL1 = CW'(T_PDL - 1);
    localparam logic [CW-1:0] C_SMP  = CW'(T_SMP);
    localparam logic [CW-1:0] C_RD01 = CW'(T_RD0 - 1);
    localparam logic [CW-1:0] C_GLT  = CW'(T_SMP / 32);

    typedef enum logic [2:0] {
        IDLE,
        SLOT,
        RST_LOW,
        PRES_WAIT,
        PRES_DRV,
        PRES_END
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          sync_1;
    logic          line_s;
    logic          line_d;
    logic          fall;
    logic          rise;
    logic          owr_e_nxt;
    logic          smp;
    logic          bit_end;
    logic          drv0;
    logic          rst_ent;
    logic          tx_acc;
    logic [2:0]    bit_cnt;
    logic [7:0]    rx_sr;
    logic [7:0]    rx_nxt;
    logic [7:0]    tx_sr;
    logic          tx_act;

    // Idle line is high, so the synchronizer resets to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b1;
            line_s <= 1'b1;
            line_d <= 1'b1;
        end else begin
            sync_1 <= owr_i;
            line_s <= sync_1;
            line_d <= line_s;
        end
    end

    assign fall = line_d & ~line_s;
    assign rise = ~line_d & line_s;

    assign drv0    = tx_act & ~tx_sr[0];
    assign rst_ent = (state_nxt == RST_LOW) && (state != RST_LOW);
    assign rx_nxt  = smp ? {line_s, rx_sr[7:1]} : rx_sr;

    assign tx_rdy = ~tx_act && (bit_cnt == 3'd0) &&
                    ((state == IDLE) || (state == PRES_WAIT) ||
                     (state == PRES_END));
    assign tx_acc = tx_vld & tx_rdy;

    always_comb begin
        state_nxt = state;
        owr_e_nxt = 1'b0;
        smp       = 1'b0;
        bit_end   = 1'b0;
        unique case (state)
            IDLE: begin
                if (fall) begin
                    state_nxt = SLOT;
                    owr_e_nxt = drv0;
                end
            end
            SLOT: begin
                // A 0 bit is held low for exactly T_RD0 cycles.
                owr_e_nxt = owr_e & (cnt != C_RD01);
                smp = (cnt == C_SMP) |
                      (rise & (cnt >= C_GLT) & (cnt < C_SMP));
                if (rise) begin
                    state_nxt = IDLE;
                    owr_e_nxt = 1'b0;
                    bit_end   = (cnt >= C_GLT);
                end else if (cnt == C_RST) begin
                    state_nxt = RST_LOW;
                end
            end
            RST_LOW: begin
                if (rise) begin
                    state_nxt = PRES_WAIT;
                end
            end
            PRES_WAIT: begin
                if (fall) begin
                    state_nxt = SLOT;
                    owr_e_nxt = drv0;
                end else if (cnt == C_PDH) begin
                    state_nxt = PRES_DRV;
                    owr_e_nxt = 1'b1;
                end
            end
            PRES_DRV: begin
                owr_e_nxt = 1'b1;
                if (cnt == C_PDL1) begin
                    state_nxt = PRES_END;
                    owr_e_nxt = 1'b0;
                end
            end
            PRES_END: begin
                // Other slaves may still hold their presence pulse.
                if (line_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owr_e   <= 1'b0;
            bus_rst <= 1'b0;
            rx_vld  <= 1'b0;
            tx_done <= 1'b0;
            rx_data <= 8'h00;
            rx_sr   <= 8'h00;
            tx_sr   <= 8'h00;
            tx_act  <= 1'b0;
            bit_cnt <= 3'd0;
        end else begin
            owr_e   <= owr_e_nxt;
            bus_rst <= 1'b0;
            rx_vld  <= 1'b0;
            tx_done <= 1'b0;
            if (rst_ent) begin
                bus_rst <= 1'b1;
                bit_cnt <= 3'd0;
                rx_sr   <= 8'h00;
                tx_act  <= 1'b0;
            end else begin
                if (smp) begin
                    rx_sr <= rx_nxt;
                end
                if (bit_end) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (tx_act) begin
                        tx_sr <= {1'b0, tx_sr[7:1]};
                    end
                    if (bit_cnt == 3'd7) begin
                        rx_vld  <= 1'b1;
                        rx_data <= rx_nxt;
                        tx_done <= tx_act;
                        tx_act  <= 1'b0;
                    end
                end
                if (tx_acc) begin
                    tx_sr  <= tx_data;
                    tx_act <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_onewire_slave.sv
// Directed bench for onewire_slave: bus reset/presence, write and read
// bytes, glitch rejection, reset mid-transmit, async reset in presence.
module tb_onewire_slave;

    localparam int T_RST = 13107;
    localparam int T_PDH = 983;
    localparam int T_PDL = 3932;
    localparam int T_RD0 = 1311;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       owr_i;
    logic       owr_e;
    logic       bus_rst;
    logic [7:0] rx_data;
    logic       rx_vld;
    logic [7:0] tx_data;
    logic       tx_vld;
    logic       tx_rdy;
    logic       tx_done;
    logic       m_low;

    always #15 clk = ~clk;

    // Open-drain wire-AND of master and slave.
    assign owr_i = ~(m_low | owr_e);

    onewire_slave dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .owr_i   (owr_i),
        .owr_e   (owr_e),
        .bus_rst (bus_rst),
        .rx_data (rx_data),
        .rx_vld  (rx_vld),
        .tx_data (tx_data),
        .tx_vld  (tx_vld),
        .tx_rdy  (tx_rdy),
        .tx_done (tx_done)
    );

    typedef struct {
        logic       rd;
        logic [7:0] data;
        logic       glitch;
        logic [7:0] exp_rx;
        logic [7:0] drv;
    } vec_t;

    int         n_chk  = 0;
    int         n_err  = 0;
    int         n_rx   = 0;
    int         n_done = 0;
    int         n_rst  = 0;
    int         n_pair = 0;
    logic [7:0] rx_last = 8'h00;

    always @(negedge clk) begin
        if (rx_vld) begin
            n_rx    <= n_rx + 1;
            rx_last <= rx_data;
        end
        if (tx_done) n_done <= n_done + 1;
        if (bus_rst) n_rst <= n_rst + 1;
        if (tx_done && !rx_vld) n_pair <= n_pair + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act,
                           input int lo, input int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // One master slot; counts cycles the slave pulls the line low.
    task automatic slot(input int lo, input int hi, output int drv);
        drv = 0;
        m_low = 1'b1;
        repeat (lo) begin
            @(negedge clk);
            if (owr_e) drv++;
        end
        m_low = 1'b0;
        repeat (hi) begin
            @(negedge clk);
            if (owr_e) drv++;
        end
    endtask

    task automatic bus_reset(input int lo);
        int t_rst;
        int t_lo;
        int t_hi;
        int r0;
        t_rst = -1;
        t_lo  = -1;
        t_hi  = -1;
        r0    = n_rst;
        m_low = 1'b1;
        for (int i = 1; i <= lo; i++) begin
            @(negedge clk);
            if (bus_rst && t_rst < 0) t_rst = i;
        end
        m_low = 1'b0;
        for (int i = 1; i <= 5000; i++) begin
            @(negedge clk);
            if (owr_e) begin
                t_lo = i - 1;
                break;
            end
        end
        if (t_lo >= 0) begin
            for (int i = 1; i <= 5000; i++) begin
                @(negedge clk);
                if (!owr_e) begin
                    t_hi = i;
                    break;
                end
            end
        end
        repeat (50) @(negedge clk);
        chk_rng("bus_rst delay", t_rst, T_RST, T_RST + 5);
        chk("bus_rst pulses", n_rst - r0, 1);
        chk_rng("presence delay", t_lo, T_PDH, T_PDH + 4);
        chk("presence width", t_hi, T_PDL);
        chk("owr_e after presence", owr_e, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int r_rx;
        int r_dn;
        int d;
        int dsum;
        r_rx = n_rx;
        r_dn = n_done;
        dsum = 0;
        if (v.rd) begin
            chk("tx_rdy before accept", tx_rdy, 1);
            tx_data = v.data;
            tx_vld  = 1'b1;
            @(negedge clk);
            tx_vld  = 1'b0;
            tx_data = 8'h00;
            chk("tx_rdy after accept", tx_rdy, 0);
        end
        for (int b = 0; b < 8; b++) begin
            if (v.glitch && b == 4) begin
                slot(10, 200, d);
                dsum += d;
            end
            if (v.rd) begin
                slot(66, v.drv[b] ? 1300 : 200, d);
                chk($sformatf("read slot %0d drive", b), d,
                    v.drv[b] ? T_RD0 : 0);
            end else begin
                slot(v.data[b] ? 197 : 1966, 200, d);
                dsum += d;
            end
        end
        repeat (10) @(negedge clk);
        chk("rx_vld count", n_rx - r_rx, 1);
        chk("rx_data", int'(rx_last), int'(v.exp_rx));
        chk("tx_done count", n_done - r_dn, v.rd ? 1 : 0);
        chk("tx_rdy after byte", tx_rdy, 1);
        if (!v.rd) chk("write owr_e cycles", dsum, 0);
    endtask

    vec_t vt[3];
    vec_t w5a;

    initial begin
        int d;
        int r_dn;
        int r_rx;
        int ok;

        vt[0] = '{1'b0, 8'hA5, 1'b1, 8'hA5, 8'h00};
        vt[1] = '{1'b1, 8'h3C, 1'b0, 8'h3C, 8'hC3};
        vt[2] = '{1'b1, 8'hFF, 1'b0, 8'hFF, 8'h00};
        w5a   = '{1'b0, 8'h5A, 1'b0, 8'h5A, 8'h00};

        rst_n   = 1'b0;
        m_low   = 1'b0;
        tx_vld  = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset owr_e", owr_e, 0);
        chk("reset bus_rst", bus_rst, 0);
        chk("reset rx_vld", rx_vld, 0);
        chk("reset tx_done", tx_done, 0);
        chk("reset rx_data", int'(rx_data), 0);
        chk("reset tx_rdy", tx_rdy, 1);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        bus_reset(16384);

        for (int v = 0; v < 3; v++) begin
            run_vec(vt[v]);
        end

        m_low = 1'b1;
        repeat (13300) @(negedge clk);
        m_low = 1'b0;
        ok = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (owr_e) begin
                ok = 1;
                break;
            end
        end
        chk("presence starts", ok, 1);
        repeat (1000) @(negedge clk);
        chk("owr_e mid presence", owr_e, 1);
        rst_n = 1'b0;
        #1;
        chk("async owr_e", owr_e, 0);
        chk("async bus_rst", bus_rst, 0);
        chk("async rx_vld", rx_vld, 0);
        chk("async tx_done", tx_done, 0);
        chk("async rx_data", int'(rx_data), 0);
        chk("async tx_rdy", tx_rdy, 1);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("owr_e after async", owr_e, 0);

        r_dn = n_done;
        r_rx = n_rx;
        chk("tx_rdy before abort", tx_rdy, 1);
        tx_data = 8'h00;
        tx_vld  = 1'b1;
        @(negedge clk);
        tx_vld  = 1'b0;
        chk("tx_rdy busy abort", tx_rdy, 0);
        for (int s = 0; s < 3; s++) begin
            slot(66, 1300, d);
            chk($sformatf("abort slot %0d drive", s), d, T_RD0);
        end
        bus_reset(13300);
        chk("abort tx_done", n_done - r_dn, 0);
        chk("abort rx_vld", n_rx - r_rx, 0);
        chk("tx_rdy after abort", tx_rdy, 1);
        run_vec(w5a);

        chk("tx_done without rx_vld", n_pair, 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
